// File: rtl/uart_tx_dport_if.sv
// rtl/uart_tx_dport_if.sv - mem_d data-port bundle between the core (master) and a responder (slave)
interface uart_tx_dport_if;
   logic [31:0] mem_d_addr_i;
   logic [31:0] mem_d_data_wr_i;
   logic        mem_d_rd_i;
   logic [3:0]  mem_d_wr_i;
   logic [10:0] mem_d_req_tag_i;
   logic        mem_d_accept_o;
   logic        mem_d_ack_o;
   logic        mem_d_error_o;
   logic [10:0] mem_d_resp_tag_o;
   logic [31:0] mem_d_data_rd_o;

   modport slave (
      input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
      output mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o
   );

   modport master (
      output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
      input  mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o, mem_d_data_rd_o
   );
endinterface

// File: rtl/uart_tx_dport.sv
// rtl/uart_tx_dport.sv - mem_d UART window (TXDATA/STATUS/DIV), TX FIFO and 8N1 serializer
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_dport #(
   parameter logic [31:0] BASE_ADDR  = 32'h92000000,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   uart_tx_dport_if.slave        bus,
   output logic                  tx_o,
   output logic                  irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [15:0]   div_q, div_d;
   state_t        state_q;
   logic [15:0]   baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q, irq_q;
`ifdef UART_TX_PARITY_EN
   logic          par_q;
`endif
   logic          ack_q, err_q, err_d;
   logic [10:0]   tag_q;
   logic [31:0]   rdata_q, rdata_d;

   logic [3:0]    off;
   logic          hit, is_wr, req, sel_tx, sel_st, sel_div;
   logic          full, empty, accept, take, push, pop;
   logic [3:0]    cnt_sat;
   logic          unused_wdata;

   assign off     = bus.mem_d_addr_i[3:0];
   assign hit     = bus.mem_d_addr_i[31:4] == BASE_ADDR[31:4];
   assign is_wr   = |bus.mem_d_wr_i;
   assign req     = bus.mem_d_rd_i | is_wr;
   assign sel_tx  = hit & (off == 4'h0);
   assign sel_st  = hit & (off == 4'h4);
   assign sel_div = hit & (off == 4'h8);
   assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign empty   = cnt_q == '0;
   // Only a TXDATA write can be stalled; everything else is taken immediately.
   assign accept  = !(is_wr & sel_tx & full);
   assign take    = req & accept;
   assign push    = take & is_wr & sel_tx & bus.mem_d_wr_i[0];
   assign pop     = !empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & (baud_q == 16'd0)));
   assign cnt_sat = (32'(cnt_q) > 32'd15) ? 4'hF : 4'(cnt_q);
   assign unused_wdata = ^bus.mem_d_data_wr_i[31:16];

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push && pop)
         cnt_d = cnt_q - 1'b1;

      div_d = div_q;
      if (take && is_wr && sel_div)
         div_d = (bus.mem_d_data_wr_i[15:0] < 16'd2) ? 16'd2 : bus.mem_d_data_wr_i[15:0];

      rdata_d = 32'h0;
      if (!is_wr && sel_st)
         rdata_d = {24'h0, cnt_sat, PAR_FLAG, empty, full, state_q != S_IDLE};
      else if (!is_wr && sel_div)
         rdata_d = {16'h0, div_q};
      err_d = !(sel_tx | sel_st | sel_div);
   end

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_q[wr_ptr_q] <= bus.mem_d_data_wr_i[7:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         div_q    <= DIV_RESET;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         tag_q    <= 11'h0;
         rdata_q  <= 32'h0;
         irq_q    <= 1'b1;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
         div_q <= div_d;
         ack_q <= take;
         if (take) begin
            err_q   <= err_d;
            tag_q   <= bus.mem_d_req_tag_i;
            rdata_q <= rdata_d;
         end
         irq_q <= empty & (state_q == S_IDLE);
      end
   end

   // Every bit period reloads from div_q, so DIV writes land at the next bit boundary.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  baud_q  <= div_q - 16'd1;
                  shift_q <= fifo_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                  par_q   <= ^fifo_q[rd_ptr_q];
`endif
               end
            end
            S_START: begin
               if (baud_q == 16'd0) begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
                  bit_q   <= 3'd0;
                  baud_q  <= div_q - 16'd1;
               end else
                  baud_q <= baud_q - 16'd1;
            end
            S_DATA: begin
               if (baud_q == 16'd0) begin
                  baud_q <= div_q - 16'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= S_PARITY;
                     tx_q    <= par_q;
`else
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else
                  baud_q <= baud_q - 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_q == 16'd0) begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
                  baud_q  <= div_q - 16'd1;
               end else
                  baud_q <= baud_q - 16'd1;
            end
`endif
            S_STOP: begin
               if (baud_q == 16'd0) begin
                  if (!empty) begin
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                     baud_q  <= div_q - 16'd1;
                     shift_q <= fifo_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                     par_q   <= ^fifo_q[rd_ptr_q];
`endif
                  end else
                     state_q <= S_IDLE;
               end else
                  baud_q <= baud_q - 16'd1;
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.mem_d_accept_o   = accept;
   assign bus.mem_d_ack_o      = ack_q;
   assign bus.mem_d_error_o    = err_q;
   assign bus.mem_d_resp_tag_o = tag_q;
   assign bus.mem_d_data_rd_o  = rdata_q;
   assign tx_o                 = tx_q;
   assign irq_o                = irq_q;
endmodule
